adder_bist_checker: RTL

- Hardware self-test engine for the team's 8-bit ripple full adder.
- Generates operand vectors (A, B, cin) and drives them into the adder.
- Reads back sum/cout, compares each result against an internally computed reference, and reports pass/fail, the error count and the first failing vector.
- Sits beside the adder in the datapath and takes the place of the simulation testbench in silicon bring-up.

---
 rtl/adder_bist_checker.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/adder_bist_checker.sv
`default_nettype none
// ============================================================================
// Module      : adder_bist_checker
// Description : Built-in self-test engine for a WIDTH-bit ripple full adder.
//               Drives operand vectors (zero vector, all-ones carry vector,
//               then a 16-bit Fibonacci LFSR stream). Checks each registered
//               result one cycle after it is applied. Reports pass/fail, a
//               saturating error count and the first failing vector.
//               Optional macro BIST_FAULT_INJECT_EN adds an inject_fault input
//               that flips captured sum bit 0 before the comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_bist_checker #(
  parameter int          WIDTH       = 8,
  parameter int          NUM_VECTORS = 256,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef BIST_FAULT_INJECT_EN
  input  logic             inject_fault,
`endif
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_cin
);

  // A zero seed would lock the LFSR, so it falls back to the default seed.
  localparam logic [15:0] c_seed = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [15:0] c_last = 16'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_launch;
  logic             w_step;
  logic             w_finish;

  logic [15:0]      r_idx;
  logic [15:0]      r_lfsr;
  logic [15:0]      w_lfsr_adv;
  logic [WIDTH:0]   r_exp;
  logic             r_cmp_valid;

  logic [WIDTH-1:0] w_vec_a;
  logic [WIDTH-1:0] w_vec_b;
  logic             w_vec_cin;
  logic [WIDTH:0]   w_vec_exp;

  logic             w_flip;
  logic [WIDTH:0]   w_got;
  logic             w_mismatch;
  logic [7:0]       w_err_next;

`ifdef BIST_FAULT_INJECT_EN
  assign w_flip = inject_fault;
`else
  assign w_flip = 1'b0;
`endif

  // State register; reset aborts any run in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    w_next   = r_state;
    w_launch = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_next   = RUN;
          w_launch = 1'b1;
        end
      end
      RUN: begin
        // start is not examined here, so a pulse mid-run has no effect.
        w_step = 1'b1;
        if (r_idx == c_last) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        w_finish = 1'b1;
        w_next   = DONE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Shift-left Fibonacci LFSR with taps 15,13,12,10.
  assign w_lfsr_adv = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

  // Vector to drive next: vector 0 on launch, the wrap vector at index 1,
  // otherwise derived from the freshly advanced LFSR state.
  always_comb begin
    w_vec_a   = '0;
    w_vec_b   = '0;
    w_vec_cin = 1'b0;
    if (w_launch) begin
      w_vec_a   = '0;
      w_vec_b   = '0;
      w_vec_cin = 1'b0;
    end else if (r_idx == 16'd1) begin
      w_vec_a   = '1;
      w_vec_b   = WIDTH'(1);
      w_vec_cin = 1'b0;
    end else begin
      w_vec_a   = WIDTH'(w_lfsr_adv[15:8]);
      w_vec_b   = WIDTH'(w_lfsr_adv[7:0]);
      w_vec_cin = w_lfsr_adv[15] ^ w_lfsr_adv[0];
    end
  end

  assign w_vec_exp = {1'b0, w_vec_a} + {1'b0, w_vec_b} + (WIDTH+1)'(w_vec_cin);

  // The adder output seen now belongs to the vector registered last edge.
  assign w_got      = {dut_cout, dut_sum ^ WIDTH'(w_flip)};
  assign w_mismatch = r_cmp_valid && (w_got != r_exp);
  assign w_err_next = (w_mismatch && (err_count != 8'hFF)) ? (err_count + 8'd1) : err_count;

  // Vector generation, result checking and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dut_a       <= '0;
      dut_b       <= '0;
      dut_cin     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= 8'd0;
      fail_a      <= '0;
      fail_b      <= '0;
      fail_cin    <= 1'b0;
      r_idx       <= 16'd0;
      r_lfsr      <= c_seed;
      r_exp       <= '0;
      r_cmp_valid <= 1'b0;
    end else if (w_launch) begin
      // Every run restarts from the seed so runs are repeatable.
      err_count   <= 8'd0;
      fail_a      <= '0;
      fail_b      <= '0;
      fail_cin    <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      busy        <= 1'b1;
      r_idx       <= 16'd1;
      r_lfsr      <= c_seed;
      dut_a       <= w_vec_a;
      dut_b       <= w_vec_b;
      dut_cin     <= w_vec_cin;
      r_exp       <= w_vec_exp;
      r_cmp_valid <= 1'b1;
    end else begin
      if (r_cmp_valid) begin
        err_count <= w_err_next;
        if (w_mismatch && (err_count == 8'd0)) begin
          fail_a   <= dut_a;
          fail_b   <= dut_b;
          fail_cin <= dut_cin;
        end
      end
      if (w_step) begin
        dut_a   <= w_vec_a;
        dut_b   <= w_vec_b;
        dut_cin <= w_vec_cin;
        r_exp   <= w_vec_exp;
        r_idx   <= r_idx + 16'd1;
        if (r_idx != 16'd1) begin
          r_lfsr <= w_lfsr_adv;
        end
      end
      if (w_finish) begin
        r_cmp_valid <= 1'b0;
        busy        <= 1'b0;
        done        <= 1'b1;
        pass        <= (w_err_next == 8'd0);
      end
    end
  end

endmodule
`default_nettype wire
